// File: rtl/dmem_io_responder_if.sv
// Data-memory port between the single-cycle core and its responder.
//   we_dm : store strobe (core -> responder)
//   addr  : byte address (core -> responder)
//   wd_dm : store data   (core -> responder)
//   rd_dm : load data, combinational (responder -> core)
// Transfer rule: there is no valid/ready pair. Every cycle is an access; the
// load result on rd_dm is valid in the same cycle as addr, and a store is
// committed on the rising edge that ends a cycle in which we_dm is high.
interface dmem_io_responder_if;
    logic        we_dm;
    logic [31:0] addr;
    logic [31:0] wd_dm;
    logic [31:0] rd_dm;

    modport master (output we_dm, output addr, output wd_dm, input rd_dm);
    modport slave  (input we_dm, input addr, input wd_dm, output rd_dm);
endinterface

// File: rtl/dmem_io_responder.sv
// Data-side responder for the single-cycle MIPS core: word-addressed RAM plus
// a memory-mapped I/O block (GPIO out/in, down-counting timer with sticky
// done flag, store counter). Loads are combinational, stores land on the edge.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   bus          : data-memory port (slave side), see dmem_io_responder_if
//   gpio_in      : asynchronous external inputs, 2-flop synchronized
//   gpio_out     : registered GPIO output register
//   timer_done   : sticky timer-expired flag
//   timer_state  : debug view of the timer FSM (1 = RUN, 0 = IDLE)
// Address map (decode on addr[11:8], everything else aliases):
//   0x0xx RAM, index addr[log2(DEPTH)+1:2]
//   0x800 GPIO_OUT  0x804 GPIO_IN  0x808 TIMER  0x80C STATUS  0x810 WCOUNT
module dmem_io_responder #(
    parameter int DEPTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_io_responder_if.slave   bus,
    input  logic [31:0]          gpio_in,
    output logic [31:0]          gpio_out,
    output logic                 timer_done,
    output logic                 timer_state
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } timer_state_e;

    // ---------------- address decode ----------------
    logic [3:0]    region;
    logic [7:0]    offset;
    logic [AW-1:0] ram_idx;
    logic          sel_ram, sel_io;
    logic          hit_gpo, hit_gpi, hit_tmr, hit_sts, hit_wc;
    logic          wr_ram, wr_gpo, wr_tmr, wr_sts, wr_counted;

    assign region  = bus.addr[11:8];
    assign offset  = bus.addr[7:0];
    assign ram_idx = bus.addr[AW+1:2];

    assign sel_ram = (region == 4'h0);
    assign sel_io  = (region == 4'h8);
    assign hit_gpo = sel_io && (offset == 8'h00);
    assign hit_gpi = sel_io && (offset == 8'h04);
    assign hit_tmr = sel_io && (offset == 8'h08);
    assign hit_sts = sel_io && (offset == 8'h0C);
    assign hit_wc  = sel_io && (offset == 8'h10);

    assign wr_ram = bus.we_dm && sel_ram;
    assign wr_gpo = bus.we_dm && hit_gpo;
    assign wr_tmr = bus.we_dm && hit_tmr;
    assign wr_sts = bus.we_dm && hit_sts;
    // Only writable mapped locations are counted; RO/unmapped stores are not.
    assign wr_counted = wr_ram || wr_gpo || wr_tmr || wr_sts;

    // Upper address bits and byte offset are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^bus.addr;

    // ---------------- RAM (no reset) ----------------
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_ram) begin
            mem[ram_idx] <= bus.wd_dm;
        end
    end

    // ---------------- GPIO and store counter ----------------
    logic [31:0] gpi_sync1, gpi_sync2;
    logic [31:0] wcount;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_out  <= 32'd0;
            gpi_sync1 <= 32'd0;
            gpi_sync2 <= 32'd0;
            wcount    <= 32'd0;
        end else begin
            gpi_sync1 <= gpio_in;
            gpi_sync2 <= gpi_sync1;
            if (wr_gpo) begin
                gpio_out <= bus.wd_dm;
            end
            if (wr_counted) begin
                wcount <= wcount + 32'd1;
            end
        end
    end

    // ---------------- timer FSM ----------------
    timer_state_e state;
    logic [31:0]  count;
    logic         done;
    logic         expire;
    logic         done_set;

    // A reload on the same edge as expiry restarts the timer, so expiry only
    // sets done when no TIMER store is present.
    assign expire   = (state == T_RUN) && (count == 32'd1);
    assign done_set = (wr_tmr && (bus.wd_dm == 32'd0)) || (!wr_tmr && expire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= T_IDLE;
            count <= 32'd0;
            done  <= 1'b0;
        end else begin
            if (wr_tmr) begin
                if (bus.wd_dm != 32'd0) begin
                    count <= bus.wd_dm;
                    state <= T_RUN;
                end else begin
                    count <= 32'd0;
                    state <= T_IDLE;
                end
            end else if (state == T_RUN) begin
                if (count == 32'd1) begin
                    count <= 32'd0;
                    state <= T_IDLE;
                end else begin
                    count <= count - 32'd1;
                end
            end
            // Set has priority over a write-1-to-clear on the same edge.
            if (done_set) begin
                done <= 1'b1;
            end else if (wr_sts && bus.wd_dm[0]) begin
                done <= 1'b0;
            end
        end
    end

    assign timer_done  = done;
    assign timer_state = (state == T_RUN);

    // ---------------- combinational load path ----------------
    always_comb begin
        bus.rd_dm = 32'd0;
        if (sel_ram) begin
            bus.rd_dm = mem[ram_idx];
        end else if (hit_gpo) begin
            bus.rd_dm = gpio_out;
        end else if (hit_gpi) begin
            bus.rd_dm = gpi_sync2;
        end else if (hit_tmr) begin
            bus.rd_dm = count;
        end else if (hit_sts) begin
            bus.rd_dm = {30'd0, (state == T_RUN), done};
        end else if (hit_wc) begin
            bus.rd_dm = wcount;
        end
    end
endmodule

// File: tb/tb_dmem_io_responder.sv
// Bench for dmem_io_responder: directed scenarios followed by random accesses,
// checked against a reference model that tracks the timer as an absolute
// expiry edge number and GPIO_IN as a history of sampled input values.
module tb_dmem_io_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic        timer_done;
    logic        timer_state;

    dmem_io_responder_if bus ();

    dmem_io_responder #(.DEPTH(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .timer_done  (timer_done),
        .timer_state (timer_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          kind_q[$];
    logic [31:0] addr_q[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic push(input logic [31:0] e, input int k, input logic [31:0] a);
        exp_q.push_back(e);
        kind_q.push_back(k);
        addr_q.push_back(a);
    endtask

    // Monitor: outputs are settled by the falling edge; drain every check
    // queued for this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [31:0] e, act, a;
            int k;
            e = exp_q.pop_front();
            k = kind_q.pop_front();
            a = addr_q.pop_front();
            case (k)
                0:       act = bus.rd_dm;
                1:       act = gpio_out;
                2:       act = {31'd0, timer_done};
                default: act = {31'd0, timer_state};
            endcase
            checks++;
            if (act !== e) begin
                failures++;
                case (k)
                    0: $display("FAIL rd_dm addr=%h actual=%h expected=%h t=%0t", a, act, e, $time);
                    1: $display("FAIL gpio_out actual=%h expected=%h t=%0t", act, e, $time);
                    2: $display("FAIL timer_done actual=%0d expected=%0d t=%0t", act, e, $time);
                    default: $display("FAIL timer_state actual=%0d expected=%0d t=%0t", act, e, $time);
                endcase
            end
        end
    end

    // ---------------- reference model ----------------
    int          e_cur;                // rising edges seen so far
    logic [31:0] m_ram [int];
    logic [31:0] m_gpo;
    logic [31:0] m_wc;
    bit          t_run;
    int          t_deadline;           // edge number at which the timer expires
    bit          t_done;
    logic [31:0] gin_at [int];         // gpio_in value captured at edge n
    logic [31:0] gin_drive;

    task automatic model_reset();
        m_gpo  = 32'd0;
        m_wc   = 32'd0;
        t_run  = 1'b0;
        t_done = 1'b0;
        gin_at.delete();
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a, output bit known);
        logic [3:0] reg_n;
        logic [7:0] off;
        reg_n = a[11:8];
        off   = a[7:0];
        known = 1'b1;
        ref_read = 32'd0;
        if (reg_n == 4'h0) begin
            if (m_ram.exists(int'(a[7:2]))) ref_read = m_ram[int'(a[7:2])];
            else known = 1'b0;
        end else if (reg_n == 4'h8) begin
            case (off)
                8'h00: ref_read = m_gpo;
                // synchronized value seen now was presented two edges ago
                8'h04: ref_read = gin_at.exists(e_cur - 1) ? gin_at[e_cur - 1] : 32'd0;
                8'h08: ref_read = t_run ? 32'(t_deadline - e_cur) : 32'd0;
                8'h0C: ref_read = {30'd0, t_run, t_done};
                8'h10: ref_read = m_wc;
                default: ref_read = 32'd0;
            endcase
        end
    endfunction

    // One core cycle: present the access, queue expectations from the
    // pre-edge state, then apply the edge to the model.
    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] e;
        bit known, set_done, clr_done, loaded;
        logic [3:0] reg_n;
        logic [7:0] off;
        bus.we_dm = we;
        bus.addr  = a;
        bus.wd_dm = wd;
        gpio_in   = gin_drive;
        e = ref_read(a, known);
        if (known) push(e, 0, a);
        push(m_gpo, 1, a);
        push({31'd0, t_done}, 2, a);
        push({31'd0, t_run}, 3, a);
        @(posedge clk);
        e_cur++;
        reg_n = a[11:8];
        off   = a[7:0];
        if (we && reg_n == 4'h0) m_ram[int'(a[7:2])] = wd;
        if (!rst) begin
            gin_at[e_cur] = gin_drive;
            set_done = 1'b0;
            clr_done = 1'b0;
            loaded   = 1'b0;
            if (we && reg_n == 4'h0) m_wc++;
            if (we && reg_n == 4'h8) begin
                if (off == 8'h00) begin m_gpo = wd; m_wc++; end
                if (off == 8'h08) begin
                    m_wc++;
                    loaded = 1'b1;
                    if (wd != 32'd0) begin
                        t_run = 1'b1;
                        t_deadline = e_cur + int'(wd);
                    end else begin
                        t_run = 1'b0;
                        set_done = 1'b1;
                    end
                end
                if (off == 8'h0C) begin m_wc++; clr_done = wd[0]; end
            end
            if (!loaded && t_run && e_cur == t_deadline) begin
                t_run = 1'b0;
                set_done = 1'b1;
            end
            if (set_done) t_done = 1'b1;
            else if (clr_done) t_done = 1'b0;
        end
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] up;
        logic [7:0]  offs [7];
        int r;
        offs[0] = 8'h00; offs[1] = 8'h04; offs[2] = 8'h08; offs[3] = 8'h0C;
        offs[4] = 8'h10; offs[5] = 8'h14; offs[6] = 8'($urandom);
        up = $urandom;
        r  = $urandom_range(0, 9);
        if (r < 5) rand_addr = {up[19:0], 4'h0, 8'($urandom)};
        else if (r < 9) rand_addr = {up[19:0], 4'h8, offs[$urandom_range(0, 6)]};
        else rand_addr = {up[19:0], (($urandom_range(0, 1) == 0) ? 4'h4 : 4'hF), 8'($urandom)};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        bus.we_dm = 1'b0;
        bus.addr  = 32'd0;
        bus.wd_dm = 32'd0;
        gpio_in   = 32'd0;
        gin_drive = 32'd0;
        e_cur     = 0;
        t_deadline = 0;
        model_reset();
        @(posedge clk);
        #1;

        // reset state
        step(0, 32'h810, 0);
        step(0, 32'h80C, 0);
        rst = 1'b0;

        // RAM store/load, same-cycle read returns the old word
        step(1, 32'h0000_0010, 32'hDEAD_BEEF);
        step(1, 32'h0000_0014, 32'hCAFE_F00D);
        step(0, 32'h0000_0010, 0);
        step(0, 32'h0000_0014, 0);
        step(0, 32'h0000_0810, 0);
        step(1, 32'h0000_0010, 32'h1111_1111);
        step(0, 32'h0000_0010, 0);

        // GPIO out and synchronized GPIO in
        step(1, 32'h800, 32'h0000_00A5);
        step(0, 32'h800, 0);
        gin_drive = 32'h1234_5678;
        step(0, 32'h804, 0);
        step(0, 32'h804, 0);
        step(0, 32'h804, 0);
        step(1, 32'h804, 32'hFFFF_FFFF);
        step(0, 32'h810, 0);

        // timer load 5, expiry, clear
        step(1, 32'h808, 5);
        repeat (6) step(0, 32'h80C, 0);
        step(0, 32'h808, 0);
        step(1, 32'h80C, 1);
        step(0, 32'h80C, 0);

        // reload mid-run
        step(1, 32'h808, 3);
        step(0, 32'h808, 0);
        step(0, 32'h808, 0);
        step(1, 32'h808, 10);
        repeat (11) step(0, 32'h80C, 0);

        // load 0, then clear
        step(1, 32'h808, 0);
        step(0, 32'h80C, 0);
        step(1, 32'h80C, 1);

        // clear on the expiry edge: set wins
        step(1, 32'h808, 3);
        step(0, 32'h808, 0);
        step(0, 32'h808, 0);
        step(1, 32'h80C, 1);
        step(0, 32'h80C, 0);

        // async reset mid-count (count=4)
        step(1, 32'h808, 8);
        repeat (4) step(0, 32'h808, 0);
        rst = 1'b1;
        model_reset();
        step(0, 32'h808, 0);
        step(0, 32'h810, 0);
        step(0, 32'h0000_0010, 0);
        rst = 1'b0;
        step(0, 32'h800, 0);

        // unmapped, unmapped I/O offset, aliasing
        step(1, 32'h0000_0400, 32'h55);
        step(0, 32'h0000_0400, 0);
        step(1, 32'h0000_0814, 32'h66);
        step(0, 32'h0000_0814, 0);
        step(0, 32'h0000_0810, 0);
        step(1, 32'hFFFF_F010, 32'h77);
        step(0, 32'h0000_0010, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, wd;
            bit we;
            a  = rand_addr();
            we = ($urandom_range(0, 2) == 0);
            wd = $urandom;
            if (a[11:8] == 4'h8 && a[7:0] == 8'h08) wd = 32'($urandom_range(0, 12));
            gin_drive = $urandom;
            step(we, a, wd);
        end

        bus.we_dm = 1'b0;
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_io_responder.md
# dmem_io_responder

Data-side responder for the single-cycle MIPS core: it sits on the far end of the core's data-memory port (`we_dm`, address, write data, read data) and serves every load/store in the same cycle. It holds a word-addressed RAM and a small memory-mapped I/O region: GPIO output/input registers, a down-counting timer with a sticky done flag, and a store counter. Reads are combinational so the core's single-cycle timing holds; all state changes on the rising clock edge.

## Interface
- `DEPTH`, 64: RAM words, power of two, max 64; index = `addr[log2(DEPTH)+1:2]`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `we_dm`  in  1  store strobe from core.
- `addr`  in  32  byte address (core ALU output).
- `wd_dm`  in  32  store data.
- `rd_dm`  out  32  load data, combinational.
- `gpio_in`  in  32  asynchronous external inputs.
- `gpio_out`  out  32  registered GPIO output.
- `timer_done`  out  1  sticky timer-expired flag.

## Operation
- Decode on `addr[11:8]` only; `addr[31:12]` and `addr[1:0]` ignored (aliasing permitted).
  - `0x0`: RAM. Index from the `addr[7:2]` field above; upper index bits beyond `DEPTH` ignored.
  - `0x8`: I/O. Offset `addr[7:0]`:
    - `0x00` GPIO_OUT: R/W.
    - `0x04` GPIO_IN: RO, 2-flop synchronized value.
    - `0x08` TIMER: write loads count N; read returns current count.
    - `0x0C` STATUS: bit0 = done, bit1 = running, other bits read 0. Writing 1 to bit0 clears done; bit1 write ignored.
    - `0x10` WCOUNT: RO, 32-bit count of stores that hit a mapped writable location; wraps at 2^32.
  - All other addresses/offsets: reads return 0; writes ignored and not counted.
- RAM
  - Write on the clock edge when `we_dm` is set and the region is RAM.
  - Read is asynchronous.
  - RAM is not reset; contents are undefined until written.
- Timer states are IDLE (running=0) and RUN (running=1).
  - Load N≠0: count←N, running←1; done unchanged.
  - Load N=0: count←0, running←0, done←1.
  - In RUN, each cycle count←count−1. When count==1: count←0, running←0, done←1.
  - Reload while in RUN restarts from the new N.
  - Simultaneous done-set and STATUS clear: set wins.
- `timer_done` equals the done bit.
- WCOUNT increments on stores to RAM, GPIO_OUT, TIMER and STATUS. Stores to RO or unmapped locations do not count.

## Timing
- Reset (async, immediate): `gpio_out`=0, count=0, running=0, done=0 (`timer_done`=0), WCOUNT=0, sync flops=0. `rd_dm` then reflects reset state combinationally. RAM is untouched.
- Load latency is 0 cycles: `rd_dm` is valid in the same cycle as `addr`.
- Store latency is 1 edge: a read of the same location in the same cycle returns the old value.
- GPIO_IN latency: a `gpio_in` change is visible on the 2nd rising edge after it is stable.
- Timer: a load of N at edge E0 makes `timer_done` rise after edge E0+N (N≥1); for N=0 it rises after E0.
- Reset asserted mid-count aborts the timer and clears done. Deassertion needs no sync handling inside the block.

## Test plan
- Reset, then store 0xDEADBEEF to 0x0000_0010 and 0xCAFEF00D to 0x0000_0014, then load both -> returns 0xDEADBEEF and 0xCAFEF00D. Same-cycle read during the store returns the prior value. WCOUNT=2.
- Store 0x0000_00A5 to 0x800 -> `gpio_out`=0x0000_00A5 after the edge and reads back 0xA5. Drive `gpio_in`=0x1234_5678 -> reading 0x804 returns 0 after one edge and 0x1234_5678 after the second. Store to 0x804 -> no change, WCOUNT not incremented.
- Store 5 to 0x808 -> STATUS reads 0x2. `timer_done` rises exactly 5 edges later, after which STATUS reads 0x1 and TIMER reads 0. Store 1 to 0x80C -> `timer_done`=0.
- Load 3, then reload 10 after 2 cycles -> done at 10 edges after the reload. Store 0 to 0x808 -> done after 1 edge. Issue a STATUS clear on the same edge as expiry -> done stays 1.
- Assert `rst` asynchronously mid-count (count=4) -> `timer_done`=0, TIMER reads 0, `gpio_out`=0 and WCOUNT=0 with no clock edge required. A previously written RAM word still reads back.
- Access unmapped 0x0000_0400 and I/O offset 0x814 -> reads return 0, stores are ignored and WCOUNT is unchanged. Access aliased 0xFFFF_F010 -> hits RAM word 4.
